// File: rtl/ram_stream_reader.sv
// Read side of a single-clock circular buffer: issues RAM reads behind the writer's
// pointer and hides the one-cycle RAM latency with a head/skid output buffer.
module ram_stream_reader #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS:0]   wr_ptr,
  output logic [ADDR_BITS:0]   rd_ptr,
  output logic                 ram_rd_en,
  output logic [ADDR_BITS-1:0] ram_rd_addr,
  input  logic [WIDTH-1:0]     ram_rd_data,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow
);

  localparam logic [ADDR_BITS:0] DepthVal = (ADDR_BITS+1)'(DEPTH);

  logic [ADDR_BITS:0] iss_ptr_q, iss_ptr_d;
  logic [ADDR_BITS:0] rd_ptr_q, rd_ptr_d;
  logic               inflight_q, inflight_d;
  logic [1:0]         occ_q, occ_d;
  logic [WIDTH-1:0]   head_q, head_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic               overflow_q, overflow_d;

  logic               pop;
  logic               avail;
  logic               issue;
  logic [2:0]         fill;
  logic [1:0]         slot;
  logic [ADDR_BITS:0] count_w;

  // fill is the buffer occupancy after this edge before any new issue lands;
  // slot is where a returning word goes (0 = head, 1 = skid).
  always_comb begin
    pop        = (occ_q != 2'd0) && out_ready && !flush;
    avail      = (wr_ptr != iss_ptr_q);
    fill       = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue      = rst_n && avail && !flush && (fill < 3'd2);
    slot       = occ_q - {1'b0, pop};
    count_w    = wr_ptr - rd_ptr_q;

    iss_ptr_d  = iss_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = issue;
    occ_d      = fill[1:0];
    head_d     = head_q;
    skid_d     = skid_q;
    overflow_d = overflow_q | (count_w > DepthVal);

    if (issue) begin
      iss_ptr_d = iss_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (occ_q == 2'd2) begin
        head_d = skid_q;
      end
    end
    if (inflight_q) begin
      if (slot == 2'd0) begin
        head_d = ram_rd_data;
      end else begin
        skid_d = ram_rd_data;
      end
    end
    // Flush drops buffered words and any read still returning from the RAM.
    if (flush) begin
      occ_d      = 2'd0;
      inflight_d = 1'b0;
      iss_ptr_d  = wr_ptr;
      rd_ptr_d   = wr_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= '0;
      skid_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      iss_ptr_q  <= iss_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      overflow_q <= overflow_d;
    end
  end

  assign ram_rd_en   = issue;
  assign ram_rd_addr = iss_ptr_q[ADDR_BITS-1:0];
  assign rd_ptr      = rd_ptr_q;
  assign out_valid   = (occ_q != 2'd0);
  assign out_data    = head_q;
  assign count       = count_w;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM and writer model plus a scoreboard monitor
// that compares every popped word against the order the writer produced.
module tb_ram_stream_reader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AB    = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AB:0]       wr_ptr;
  logic [AB:0]       rd_ptr;
  logic              ram_rd_en;
  logic [AB-1:0]     ram_rd_addr;
  logic [WIDTH-1:0]  ram_rd_data;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic              out_ready;
  logic              flush;
  logic [AB:0]       count;
  logic              overflow;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  exp [$];

  int checks = 0;
  int errors = 0;
  bit monEn  = 1'b0;
  int cyc    = 0;
  int nPops, firstPop, lastPop;

  ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush(flush), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // RAM with one-cycle registered read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  // Scoreboard monitor: sampled at the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (monEn && rst_n) begin
      checks++;
      if (count !== 6'(exp.size())) begin
        errors++;
        $display("[TB] FAIL count: got %0d expected %0d", count, exp.size());
      end
      checks++;
      if (({1'b0, dut.occ_q} + {2'b00, dut.inflight_q}) > 3'd2) begin
        errors++;
        $display("[TB] FAIL invariant: occ %0d inflight %0d exceeds 2", dut.occ_q, dut.inflight_q);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_word: got %h expected no word", out_data);
        end else begin
          logic [WIDTH-1:0] e;
          e = exp.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("[TB] FAIL stream_data: got %h expected %h", out_data, e);
          end
        end
        if (nPops == 0) firstPop = cyc;
        lastPop = cyc;
        nPops++;
      end
    end
  end

  task automatic push(input logic [WIDTH-1:0] d);
    mem[wr_ptr[AB-1:0]] = d;
    wr_ptr = wr_ptr + 6'd1;
    exp.push_back(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_ptr = '0; out_ready = 1'b0; flush = 1'b0;
    exp.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_ptr = 6'd3; out_ready = 1'b0; flush = 1'b0;
    #12;
    checks++;
    if (rd_ptr !== 6'd0 || out_valid !== 1'b0 || out_data !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rd_ptr %0d valid %b data %h ovf %b expected 0 0 0 0",
               rd_ptr, out_valid, out_data, overflow);
    end
    checks++;
    if (ram_rd_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rd_en: got %b expected 0", ram_rd_en);
    end
    checks++;
    if (count !== 6'd3) begin
      errors++;
      $display("[TB] FAIL reset_count: got %0d expected 3", count);
    end
    wr_ptr = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    monEn = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    push(32'hA5A5A5A5);
    #1;
    checks++;
    if (ram_rd_en !== 1'b1 || ram_rd_addr !== 5'd0) begin
      errors++;
      $display("[TB] FAIL single_issue: got en %b addr %0d expected 1 0", ram_rd_en, ram_rd_addr);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_early_valid: got %b expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5) begin
      errors++;
      $display("[TB] FAIL single_valid: got valid %b data %h expected 1 a5a5a5a5", out_valid, out_data);
    end
    @(negedge clk);
    checks++;
    if (rd_ptr !== 6'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_pop: got rd_ptr %0d valid %b expected 1 0", rd_ptr, out_valid);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    monEn = 1'b1; out_ready = 1'b1; nPops = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      push(WIDTH'(i));
      #1;
      checks++;
      if (ram_rd_en !== 1'b1 || ram_rd_addr !== 5'(i)) begin
        errors++;
        $display("[TB] FAIL stream_issue: word %0d got en %b addr %0d expected 1 %0d",
                 i, ram_rd_en, ram_rd_addr, i % DEPTH);
      end
    end
    for (int k = 0; k < 50 && exp.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (nPops !== 100 || (lastPop - firstPop) !== 99) begin
      errors++;
      $display("[TB] FAIL stream_b2b: got pops %0d span %0d expected 100 99", nPops, lastPop - firstPop);
    end
    checks++;
    if (rd_ptr !== 6'd36) begin
      errors++;
      $display("[TB] FAIL stream_rd_ptr: got %0d expected 36", rd_ptr);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] stallData;
    int issues, maxOcc;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) push(32'h100 + WIDTH'(k));
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b0;
    issues = 0; maxOcc = 0; stallData = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ram_rd_en) issues++;
      if (int'(dut.occ_q) > maxOcc) maxOcc = int'(dut.occ_q);
      if (i == 0) begin
        stallData = out_data;
        checks++;
        if (out_data !== 32'h102) begin
          errors++;
          $display("[TB] FAIL bp_head: got %h expected 00000102", out_data);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== stallData) begin
          errors++;
          $display("[TB] FAIL bp_stable: got valid %b data %h expected 1 %h", out_valid, out_data, stallData);
        end
      end
    end
    checks++;
    if (issues > 1 || maxOcc !== 2) begin
      errors++;
      $display("[TB] FAIL bp_issue: got issues %0d peak occ %0d expected <=1 2", issues, maxOcc);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    #1;
    checks++;
    if (ram_rd_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: got %b expected 1", ram_rd_en);
    end
    for (int k = 0; k < 50 && exp.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp.size() != 0) begin
      errors++;
      $display("[TB] FAIL bp_drain: got %0d left expected 0", exp.size());
    end
  endtask

  task automatic test_random();
    int written, burst;
    written = 0; burst = 0;
    for (int c = 0; c < 60000 && written < 10000; c++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 1) == 1);
      if (burst == 0 && $urandom_range(0, 3) == 0) burst = $urandom_range(1, 12);
      if (burst > 0 && count < 6'(DEPTH)) begin
        push($urandom);
        written++;
        burst--;
      end
    end
    checks++;
    if (written != 10000) begin
      errors++;
      $display("[TB] FAIL random_budget: got %0d words expected 10000", written);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    for (int k = 0; k < 200 && exp.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp.size() != 0) begin
      errors++;
      $display("[TB] FAIL random_drain: got %0d left expected 0", exp.size());
    end
  endtask

  task automatic test_flush();
    monEn = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) push(32'hF0F0_0000 + WIDTH'(k));
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    #1;
    checks++;
    if (ram_rd_en !== 1'b0 || dut.occ_q !== 2'd1 || dut.inflight_q !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_setup: got en %b occ %0d inflight %b expected 0 1 1",
               ram_rd_en, dut.occ_q, dut.inflight_q);
    end
    @(posedge clk); #1 flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || rd_ptr !== wr_ptr || ram_rd_addr !== wr_ptr[AB-1:0] ||
        ram_rd_en !== 1'b0 || count !== 6'd0) begin
      errors++;
      $display("[TB] FAIL flush_state: got valid %b rd_ptr %0d addr %0d en %b count %0d expected 0 %0d %0d 0 0",
               out_valid, rd_ptr, ram_rd_addr, ram_rd_en, count, wr_ptr, wr_ptr[AB-1:0]);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_late_data: got valid %b data %h expected 0", out_valid, out_data);
      end
    end
    exp.delete();
    monEn = 1'b1;
    @(posedge clk); #1;
    push(32'h0BAD_CAFE);
    for (int k = 0; k < 20 && exp.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp.size() != 0) begin
      errors++;
      $display("[TB] FAIL flush_resume: got %0d left expected 0", exp.size());
    end
  endtask

  task automatic test_overflow_async_reset();
    logic [AB:0] base;
    monEn = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    base = rd_ptr;
    wr_ptr = base + 6'd32;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (overflow !== 1'b0 || count !== 6'd32) begin
      errors++;
      $display("[TB] FAIL ovf_at_depth: got ovf %b count %0d expected 0 32", overflow, count);
    end
    wr_ptr = base + 6'd33;
    @(posedge clk); #1;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_set: got %b expected 1", overflow);
    end
    wr_ptr = rd_ptr;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow);
    end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    checks++;
    if (rd_ptr !== 6'd0 || out_valid !== 1'b0 || out_data !== '0 || overflow !== 1'b0 ||
        ram_rd_en !== 1'b0 || count !== wr_ptr) begin
      errors++;
      $display("[TB] FAIL async_reset: got rd_ptr %0d valid %b data %h ovf %b en %b count %0d expected 0 0 0 0 0 %0d",
               rd_ptr, out_valid, out_data, overflow, ram_rd_en, count, wr_ptr);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_streaming();
    test_backpressure();
    test_random();
    test_flush();
    test_overflow_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
